matmul_chunk_scheduler: RTL and testbench

//  Sequences one sigma^T*J*sigma energy evaluation over the J-chunk datapath. Issues one memory read per
//  J chunk (J_COLS_PER_READ columns), accumulates the datapath's per-chunk block_sum into a signed energy,
//  and terminates early once the running energy reaches energy_previous. Sits between the J-memory port
//  and the MAC datapath, and owns chunk indexing, outstanding-read credit, early exit and completion.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matmul_chunk_scheduler_counter.sv | 20 ++
 rtl/matmul_chunk_scheduler.sv | 159 +++++++++++++++
 tb/tb_matmul_chunk_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the J-chunk energy scheduler.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  // Bits needed to index 0..n-1 (chunk_idx width); never narrower than 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to hold a count 0..n inclusive (issue/response/outstanding counters).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/matmul_chunk_scheduler_counter.sv
// Up counter with synchronous clear; tracks the J-chunk issue index.
module matmul_chunk_scheduler_counter #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/matmul_chunk_scheduler.sv
// Sequences one sigma^T*J*sigma evaluation: issues chunk reads, accumulates block sums,
// exits early on reaching the previous energy, and drains in-flight reads before completing.
module matmul_chunk_scheduler
  import matmul_pkg::*;
#(
  parameter int NUM_J_CHUNKS    = 64,
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ACC_WIDTH       = 16,
  parameter int ENERGY_WIDTH    = 21
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [ADDR_WIDTH-1:0]                j_base_addr,
  input  logic [ENERGY_WIDTH-1:0]              energy_previous,
  output logic                                 mem_req_valid,
  input  logic                                 mem_req_ready,
  output logic [ADDR_WIDTH-1:0]                mem_req_addr,
  input  logic                                 mem_rsp_valid,
  input  logic [ACC_WIDTH-1:0]                 block_sum,
  output logic [idx_width(NUM_J_CHUNKS)-1:0]   chunk_idx,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 early_exit,
  output logic                                 aborted,
  output logic [ENERGY_WIDTH-1:0]              energy_out
);

  localparam int IDX_W = idx_width(NUM_J_CHUNKS);
  localparam int CNT_W = cnt_width(NUM_J_CHUNKS);
  localparam int OUT_W = cnt_width(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_J_CHUNKS);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

  sched_state_e state_reg, state_next;

  logic [ADDR_WIDTH-1:0]          base_reg;
  logic signed [ENERGY_WIDTH-1:0] thr_reg;
  logic signed [ENERGY_WIDTH-1:0] acc_reg, acc_next, acc_sum, bs_ext;
  logic [CNT_W-1:0]               rsp_cnt_reg, rsp_cnt_inc;
  logic [CNT_W-1:0]               issue_cnt;
  logic [OUT_W-1:0]               out_reg, out_next;
  logic                           early_reg, early_next;
  logic                           aborted_reg, aborted_next;
  logic [ENERGY_WIDTH-1:0]        energy_reg;

  logic accept, active, req_fire, rsp_fire, run_rsp, hit, final_rsp;

  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign active   = (state_reg == RUN) || (state_reg == DRAIN);

  assign mem_req_valid = (state_reg == RUN) && (issue_cnt < LAST_CNT) && (out_reg < OUT_MAX);
  assign mem_req_addr  = base_reg + ADDR_WIDTH'(issue_cnt);
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses only count against reads we actually issued; strays after reset are dropped.
  assign rsp_fire  = mem_rsp_valid && active && (out_reg != '0);
  assign run_rsp   = rsp_fire && (state_reg == RUN);

  assign bs_ext      = {{(ENERGY_WIDTH - ACC_WIDTH){block_sum[ACC_WIDTH-1]}}, block_sum};
  assign acc_sum     = acc_reg + bs_ext;
  assign acc_next    = run_rsp ? acc_sum : acc_reg;
  assign hit         = run_rsp && (acc_sum >= thr_reg);
  assign rsp_cnt_inc = rsp_cnt_reg + 1'b1;
  assign final_rsp   = run_rsp && (rsp_cnt_inc == LAST_CNT);

  always_comb begin
    out_next = out_reg;
    case ({req_fire, rsp_fire})
      2'b10:   out_next = out_reg + 1'b1;
      2'b01:   out_next = out_reg - 1'b1;
      default: out_next = out_reg;
    endcase
  end

  matmul_chunk_scheduler_counter #(
    .WIDTH(CNT_W)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (req_fire),
    .count (issue_cnt)
  );

  always_comb begin
    state_next   = state_reg;
    early_next   = early_reg;
    aborted_next = aborted_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        // Abort outranks a threshold hit landing in the same cycle.
        if (abort) begin
          aborted_next = 1'b1;
          state_next   = (out_next == '0) ? DONE : DRAIN;
        end else if (final_rsp) begin
          early_next = hit;
          state_next = DONE;
        end else if (hit) begin
          early_next = 1'b1;
          state_next = (out_next == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (out_next == '0) state_next = DONE;
      end
      DONE: begin
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      thr_reg     <= '0;
      acc_reg     <= '0;
      rsp_cnt_reg <= '0;
      out_reg     <= '0;
      early_reg   <= 1'b0;
      aborted_reg <= 1'b0;
      energy_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        base_reg    <= j_base_addr;
        thr_reg     <= energy_previous;
        acc_reg     <= '0;
        rsp_cnt_reg <= '0;
        out_reg     <= '0;
        early_reg   <= 1'b0;
        aborted_reg <= 1'b0;
        energy_reg  <= '0;
      end else begin
        acc_reg     <= acc_next;
        out_reg     <= out_next;
        early_reg   <= early_next;
        aborted_reg <= aborted_next;
        if (run_rsp) rsp_cnt_reg <= rsp_cnt_inc;
        if ((state_next == DONE) && (state_reg != DONE)) energy_reg <= acc_next;
      end
    end
  end

  assign chunk_idx  = rsp_cnt_reg[IDX_W-1:0];
  assign busy       = active;
  assign done       = (state_reg == DONE);
  assign early_exit = early_reg;
  assign aborted    = aborted_reg;
  assign energy_out = energy_reg;

endmodule

// File: tb/tb_matmul_chunk_scheduler.sv
// Directed bench for matmul_chunk_scheduler with a fixed-latency in-order memory model.
module tb_matmul_chunk_scheduler;

  localparam int N   = 64;
  localparam int AW  = 16;
  localparam int MO  = 4;
  localparam int ACW = 16;
  localparam int EW  = 21;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [AW-1:0] j_base_addr;
  logic [EW-1:0] energy_previous;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [ACW-1:0] block_sum;
  logic [5:0]    chunk_idx;
  logic          busy, done, early_exit, aborted;
  logic [EW-1:0] energy_out;

  matmul_chunk_scheduler #(
    .NUM_J_CHUNKS(N), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO), .ACC_WIDTH(ACW), .ENERGY_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .j_base_addr(j_base_addr),
    .energy_previous(energy_previous), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid), .block_sum(block_sum),
    .chunk_idx(chunk_idx), .busy(busy), .done(done), .early_exit(early_exit), .aborted(aborted),
    .energy_out(energy_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc, req_n, rsp_n, max_out, done_cyc;
  int due_q[$];
  int lat, bs_base, bs_step, ready_mode;
  logic [AW-1:0] base, prev_addr;
  logic stab_en, idx_en, prev_stall;
  logic [EW-1:0] en_cap, exp_e, thr;
  logic ee_cap, ab_cap;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: present due response, decide ready, log handshakes, advance.
  task automatic tick();
    logic rsp_now;
    rsp_now = 1'b0;
    mem_rsp_valid = 1'b0;
    block_sum = '0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      mem_rsp_valid = 1'b1;
      block_sum = ACW'(bs_base + bs_step * rsp_n);
      rsp_now = 1'b1;
    end
    mem_req_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) != 0);
    if (stab_en && prev_stall) begin
      check("stall_valid", 64'(mem_req_valid), 64'd1);
      check("stall_addr", 64'(mem_req_addr), 64'(prev_addr));
    end
    if (rsp_now && idx_en) check("chunk_idx", 64'(chunk_idx), 64'(rsp_n % N));
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", 64'(mem_req_addr), 64'(AW'(base + req_n)));
      due_q.push_back(cyc + lat);
      req_n++;
    end
    prev_stall = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_req_addr;
    if (rsp_now) rsp_n++;
    if (req_n - rsp_n > max_out) max_out = req_n - rsp_n;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic run_eval(input int l, input int bb, input int bst, input logic [EW-1:0] th,
                          input logic [AW-1:0] b, input int rmode, input int abort_c,
                          input int restart_c, input int rst_c);
    lat = l; bs_base = bb; bs_step = bst; base = b; ready_mode = rmode;
    due_q.delete();
    cyc = 0; req_n = 0; rsp_n = 0; max_out = 0; done_cyc = -1; prev_stall = 1'b0;
    en_cap = '0; ee_cap = 1'b0; ab_cap = 1'b0;
    start = 1'b1; j_base_addr = b; energy_previous = th;
    while (cyc < 2000) begin
      if (cyc == abort_c) abort = 1'b1;
      if (cyc == restart_c) begin
        start = 1'b1;
        j_base_addr = b + 16'h0100;
        energy_previous = '0;
      end
      if (cyc == rst_c) rst = 1'b1;
      tick();
      if (cyc - 1 == rst_c) break;
      if (done === 1'b1) begin
        done_cyc = cyc;
        en_cap = energy_out;
        ee_cap = early_exit;
        ab_cap = aborted;
        tick();
        check("done_pulse", 64'(done), 64'd0);
        break;
      end
    end
    if (rst_c < 0) check("done_seen", 64'(done_cyc >= 0), 64'd1);
    mem_rsp_valid = 1'b0;
    due_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; j_base_addr = '0; energy_previous = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; block_sum = '0;
    stab_en = 1'b0; idx_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", 64'(mem_req_valid), 64'd0);
    check("rst_addr", 64'(mem_req_addr), 64'd0);
    check("rst_idx", 64'(chunk_idx), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_early", 64'(early_exit), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_energy", 64'(energy_out), 64'd0);

    // Full pass, +1 per chunk, unreachable threshold.
    idx_en = 1'b1;
    thr = 21'd1000;
    run_eval(1, 1, 0, thr, 16'h1200, 0, -1, -1, -1);
    idx_en = 1'b0;
    check("t1_reqs", 64'(req_n), 64'd64);
    check("t1_done_cyc", 64'(done_cyc), 64'd66);
    check("t1_energy", 64'(en_cap), 64'd64);
    check("t1_early", 64'(ee_cap), 64'd0);
    check("t1_aborted", 64'(ab_cap), 64'd0);

    // Threshold 35 with +10 chunks: hit on the 4th response, one read in flight drained.
    thr = 21'd35;
    run_eval(1, 10, 0, thr, 16'h0040, 0, -1, -1, -1);
    check("t2_reqs", 64'(req_n), 64'd5);
    check("t2_done_cyc", 64'(done_cyc), 64'd7);
    check("t2_energy", 64'(en_cap), 64'd40);
    check("t2_early", 64'(ee_cap), 64'd1);
    check("t2_aborted", 64'(ab_cap), 64'd0);

    // Slow memory with back-pressure: credit limit and request stability.
    stab_en = 1'b1;
    thr = 21'd1000;
    run_eval(10, 1, 0, thr, 16'hFFF0, 1, -1, -1, -1);
    stab_en = 1'b0;
    check("t3_reqs", 64'(req_n), 64'd64);
    check("t3_max_out", 64'(max_out), 64'd4);
    check("t3_energy", 64'(en_cap), 64'd64);
    check("t3_early", 64'(ee_cap), 64'd0);

    // Negative sums never reach threshold 0.
    thr = '0;
    run_eval(1, -3, 0, thr, 16'h0000, 0, -1, -1, -1);
    exp_e = -21'sd192;
    check("t4_energy", 64'(en_cap), 64'(exp_e));
    check("t4_early", 64'(ee_cap), 64'd0);
    check("t4_done_cyc", 64'(done_cyc), 64'd66);

    // Abort on the cycle the 5th response lands with 3 reads still in flight.
    thr = 21'd1000;
    run_eval(3, 7, 7, thr, 16'h0300, 0, 8, -1, -1);
    check("t5_reqs", 64'(req_n), 64'd8);
    check("t5_done_cyc", 64'(done_cyc), 64'd12);
    check("t5_energy", 64'(en_cap), 64'd105);
    check("t5_aborted", 64'(ab_cap), 64'd1);
    check("t5_early", 64'(ee_cap), 64'd0);

    // Start while busy is ignored (addresses keep original base), then reset mid-run.
    thr = 21'd1000;
    run_eval(1, 1, 0, thr, 16'h0500, 0, -1, 10, 20);
    check("t6_valid", 64'(mem_req_valid), 64'd0);
    check("t6_addr", 64'(mem_req_addr), 64'd0);
    check("t6_idx", 64'(chunk_idx), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_energy", 64'(energy_out), 64'd0);
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      block_sum = 16'd5;
      @(posedge clk);
      #1;
      check("stray_busy", 64'(busy), 64'd0);
      check("stray_energy", 64'(energy_out), 64'd0);
      check("stray_done", 64'(done), 64'd0);
    end
    mem_rsp_valid = 1'b0;
    block_sum = '0;
    run_eval(1, 2, 0, thr, 16'h0700, 0, -1, -1, -1);
    check("t6b_reqs", 64'(req_n), 64'd64);
    check("t6b_done_cyc", 64'(done_cyc), 64'd66);
    check("t6b_energy", 64'(en_cap), 64'd128);
    check("t6b_aborted", 64'(ab_cap), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
